sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one unified single-port synchronous SRAM between the CPU's instruction-fetch port and data port, replacing the separate inst/data SRAM pair. At most one access is issued per cycle. Data accesses win by default, and a starvation counter forces an instruction grant after a bounded wait. Read data returns exactly one cycle after grant and is routed back to the requester that issued it.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `STARVE_MAX`, default 4: consecutive denied cycles of `inst_req` before instruction fetch is forced to win; legal range 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  instruction read request; held with `inst_addr` until `inst_ack`.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_ack`  out  1  request accepted this cycle (combinational).
- `inst_rdata`  out  DATA_W  fetch data; meaningful only while `inst_rvalid`.
- `inst_rvalid`  out  1  registered; one-cycle pulse returning fetch data.
- `data_req`  in  1  data request; held with its fields until `data_ack`.
- `data_we`  in  DATA_W/8  byte write strobes; all-zero means read.
- `data_addr`  in  ADDR_W  data address.
- `data_wdata`  in  DATA_W  store data.
- `data_ack`  out  1  data request accepted this cycle (combinational).
- `data_rdata`  out  DATA_W  load data; meaningful only while `data_rvalid`.
- `data_rvalid`  out  1  registered; one-cycle pulse, reads only.
- `sram_en`  out  1  SRAM access enable.
- `sram_we`  out  DATA_W/8  SRAM byte write strobes.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data, valid the cycle after an enabled read.

## Operation
**Grant selection.** Evaluated combinationally each cycle while `reset` is low.
- `force_inst = inst_req & (starve_cnt == STARVE_MAX)`
- `grant_data = data_req & ~force_inst`
- `grant_inst = inst_req & ~grant_data`
- `data_ack = grant_data`; `inst_ack = grant_inst`. Both are 0 while `reset` is high.

**SRAM drive.**
- `sram_en = grant_data | grant_inst`.
- Address comes from the granted requester.
- `sram_we = grant_data ? data_we : 0`. Instruction fetch never writes.
- `sram_wdata = data_wdata`.

**Response tracking.** A 2-bit registered `resp_owner` state: NONE, INST, DATA.
- Next state is INST if `grant_inst`.
- Next state is DATA if `grant_data & (data_we == 0)`.
- Otherwise next state is NONE.
- `inst_rvalid = (resp_owner == INST)`; `data_rvalid = (resp_owner == DATA)`.
- Both rdata outputs are wired directly to `sram_rdata`.
- Writes complete at acceptance and produce no response.

**Starvation counter.** `starve_cnt` is 4 bits.
- Cleared when `inst_req` is 0 or `grant_inst` is 1.
- Incremented when `inst_req & ~grant_inst`, saturating at `STARVE_MAX`.

**Pipelining.** A new grant may issue every cycle, including the cycle in which the previous read's rvalid is high. Data and instruction grants may alternate back-to-back.

## Timing
- Grant latency: 0 cycles. `ack` is asserted in the same cycle as `req` when selected.
- Read latency: rvalid is high exactly in cycle N+1 for a read granted in cycle N.
- Throughput: 1 access per cycle.
- Reset values: `resp_owner` = NONE, `starve_cnt` = 0.
- Reset values of outputs: `inst_rvalid` = 0, `data_rvalid` = 0, `inst_ack` = 0, `data_ack` = 0, `sram_en` = 0, `sram_we` = 0.
- Reset mid-operation: a read granted in cycle N with `reset` high in cycle N+1's sampling edge gets no rvalid; the response is dropped, not replayed. Requesters must re-request after reset.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: data wins. With `starve_cnt == STARVE_MAX`: instruction wins, and `data_req` stays pending with `data_ack` = 0.
- Requester protocol: `req` and its fields must stay stable until ack. Dropping `req` before ack is legal; it clears the starvation count for `inst`.
- No outstanding-request limit beyond one in flight per cycle, so no full/empty conditions exist.

## Test plan
- **Reset:** hold `reset` 3 cycles with both reqs high -> acks 0, `sram_en` 0, rvalids 0. First cycle after release: `data_ack` 1.
- **Single read:** `inst_req` with `inst_addr` = 0x1c000000, SRAM holding 0x02800421 there -> `inst_ack` in cycle N. Cycle N+1: `inst_rvalid` = 1, `inst_rdata` = 0x02800421, `data_rvalid` = 0.
- **Write then read:** data write `data_we` = 4'hF, addr 0x100, wdata 0xDEADBEEF, then data read of 0x100 -> no rvalid after the write. `data_rvalid` one cycle after the read's ack, with `data_rdata` = 0xDEADBEEF.
- **Starvation:** `data_req` and `inst_req` held continuously, `STARVE_MAX` = 4 -> grant pattern D,D,D,D,I repeating. `starve_cnt` returns to 0 after each I.
- **Interleave:** alternate data-read and inst-read grants in back-to-back cycles -> `rvalid` pulses alternate DATA/INST in consecutive cycles, each carrying the matching address's contents.
- **Reset mid-read:** grant an inst read, assert `reset` the next cycle -> `inst_rvalid` stays 0, and `starve_cnt` = 0 after reset.

Source files
------------

// File: rtl/sram_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_rvalid,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rvalid,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t      r_resp_owner_p1;
  logic [3:0]  r_starve_cnt;

  logic        w_force_inst;
  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_data_read;

  // Stage 0: combinational grant and SRAM drive
  assign w_force_inst = inst_req & (r_starve_cnt == STARVE_LIM);
  assign w_grant_data = ~reset & data_req & ~w_force_inst;
  assign w_grant_inst = ~reset & inst_req & ~w_grant_data;
  assign w_data_read  = w_grant_data & (data_we == '0);

  assign inst_ack   = w_grant_inst;
  assign data_ack   = w_grant_data;
  assign sram_en    = w_grant_data | w_grant_inst;
  assign sram_addr  = w_grant_data ? data_addr : inst_addr;
  assign sram_we    = w_grant_data ? data_we : '0;
  assign sram_wdata = data_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_owner_p1 <= OWN_NONE;
      r_starve_cnt    <= 4'd0;
    end else begin
      if (w_grant_inst)     r_resp_owner_p1 <= OWN_INST;
      else if (w_data_read) r_resp_owner_p1 <= OWN_DATA;
      else                  r_resp_owner_p1 <= OWN_NONE;

      if (!inst_req || w_grant_inst)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt != STARVE_LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Stage 1: read response, dropped while reset is held
  assign inst_rvalid = ~reset & (r_resp_owner_p1 == OWN_INST);
  assign data_rvalid = ~reset & (r_resp_owner_p1 == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a byte-strobed SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM model: read data appears the cycle after an enabled read
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we != 4'b0) begin
        logic [31:0] w;
        w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
        mem[sram_addr] = w;
      end else begin
        sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; data_req = 1'b0; data_we = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_we = 4'h0;
    inst_addr = 32'h1c000000; data_addr = 32'h200; data_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({inst_ack, data_ack, sram_en, sram_we, inst_rvalid, data_rvalid} !== 9'b0) begin
        $display("FAIL reset_outputs cyc%0d: got ack=%b%b en=%b we=%h rv=%b%b required all 0",
                 i, inst_ack, data_ack, sram_en, sram_we, inst_rvalid, data_rvalid);
        n_err++;
      end
      n_chk++;
      if (dut.r_starve_cnt !== 4'd0) begin
        $display("FAIL reset_starve: got %0d required 0", dut.r_starve_cnt); n_err++;
      end
      n_chk++;
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    if ({data_ack, inst_ack} !== 2'b10) begin
      $display("FAIL reset_release_ack: got data/inst=%b%b required 10", data_ack, inst_ack); n_err++;
    end
    n_chk++;
    next_cycle();
    idle();
    @(negedge clk);
    if (data_rvalid !== 1'b1 || data_rdata !== 32'h11112222) begin
      $display("FAIL reset_first_read: got rv=%b data=%h required 1 11112222", data_rvalid, data_rdata); n_err++;
    end
    n_chk++;
    next_cycle();
  endtask

  task automatic test_single_read();
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    @(negedge clk);
    if (inst_ack !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 32'h1c000000 || sram_we !== 4'h0) begin
      $display("FAIL single_grant: got ack=%b en=%b addr=%h we=%h required 1 1 1c000000 0",
               inst_ack, sram_en, sram_addr, sram_we); n_err++;
    end
    n_chk++;
    next_cycle();
    idle();
    @(negedge clk);
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h02800421 || data_rvalid !== 1'b0) begin
      $display("FAIL single_resp: got irv=%b data=%h drv=%b required 1 02800421 0",
               inst_rvalid, inst_rdata, data_rvalid); n_err++;
    end
    n_chk++;
    next_cycle();
  endtask

  task automatic test_write_read();
    logic [3:0]  we_t [2]  = '{4'hF, 4'h3};
    logic [31:0] wd_t [2]  = '{32'hDEADBEEF, 32'hAAAA5555};
    logic [31:0] exp_t [2] = '{32'hDEADBEEF, 32'hDEAD5555};
    for (int k = 0; k < 2; k++) begin
      data_req = 1'b1; data_we = we_t[k]; data_addr = 32'h100; data_wdata = wd_t[k];
      @(negedge clk);
      if (data_ack !== 1'b1 || sram_we !== we_t[k] || sram_wdata !== wd_t[k] || sram_addr !== 32'h100) begin
        $display("FAIL write_drive%0d: got ack=%b we=%h wd=%h addr=%h required 1 %h %h 100",
                 k, data_ack, sram_we, sram_wdata, sram_addr, we_t[k], wd_t[k]); n_err++;
      end
      n_chk++;
      next_cycle();
      data_we = 4'h0;
      @(negedge clk);
      if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0 || data_ack !== 1'b1) begin
        $display("FAIL write_no_resp%0d: got drv=%b irv=%b ack=%b required 0 0 1",
                 k, data_rvalid, inst_rvalid, data_ack); n_err++;
      end
      n_chk++;
      next_cycle();
      idle();
      @(negedge clk);
      if (data_rvalid !== 1'b1 || data_rdata !== exp_t[k]) begin
        $display("FAIL readback%0d: got rv=%b data=%h required 1 %h", k, data_rvalid, data_rdata, exp_t[k]); n_err++;
      end
      n_chk++;
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic prev_inst;
    logic prev_data;
    prev_inst = 1'b0; prev_data = 1'b0;
    data_req = 1'b1; data_we = 4'h0; data_addr = 32'h300;
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut.r_starve_cnt !== 4'(i % 5)) begin
        $display("FAIL starve_cnt%0d: got %0d required %0d", i, dut.r_starve_cnt, i % 5); n_err++;
      end
      n_chk++;
      if (inst_ack !== (i % 5 == 4) || data_ack !== (i % 5 != 4)) begin
        $display("FAIL starve_grant%0d: got inst/data=%b%b required %b%b",
                 i, inst_ack, data_ack, (i % 5 == 4), (i % 5 != 4)); n_err++;
      end
      n_chk++;
      if (i > 0) begin
        if (inst_rvalid !== prev_inst || data_rvalid !== prev_data ||
            (prev_inst && inst_rdata !== 32'h55556666) || (prev_data && data_rdata !== 32'h33334444)) begin
          $display("FAIL starve_resp%0d: got irv=%b drv=%b rdata=%h required %b %b",
                   i, inst_rvalid, data_rvalid, sram_rdata, prev_inst, prev_data); n_err++;
        end
        n_chk++;
      end
      prev_inst = (i % 5 == 4);
      prev_data = (i % 5 != 4);
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_interleave();
    logic        isd_t [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr_t [4] = '{32'h200, 32'h1c000000, 32'h300, 32'h1c000004};
    logic [31:0] exp_t [4]  = '{32'h11112222, 32'h02800421, 32'h33334444, 32'h55556666};
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        if (isd_t[i]) begin data_req = 1'b1; data_addr = addr_t[i]; end
        else begin inst_req = 1'b1; inst_addr = addr_t[i]; end
      end
      @(negedge clk);
      if (i < 4 && (data_ack !== isd_t[i] || inst_ack !== !isd_t[i])) begin
        $display("FAIL interleave_grant%0d: got data/inst=%b%b required %b%b",
                 i, data_ack, inst_ack, isd_t[i], !isd_t[i]); n_err++;
      end
      if (i < 4) n_chk++;
      if (i > 0) begin
        if (data_rvalid !== isd_t[i-1] || inst_rvalid !== !isd_t[i-1] || sram_rdata !== exp_t[i-1]) begin
          $display("FAIL interleave_resp%0d: got drv=%b irv=%b rdata=%h required %b %b %h",
                   i, data_rvalid, inst_rvalid, sram_rdata, isd_t[i-1], !isd_t[i-1], exp_t[i-1]); n_err++;
        end
        n_chk++;
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    @(negedge clk);
    if (inst_ack !== 1'b1) begin
      $display("FAIL midreset_grant: got %b required 1", inst_ack); n_err++;
    end
    n_chk++;
    next_cycle();
    reset = 1'b1; data_req = 1'b1; data_addr = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0 || inst_ack !== 1'b0 || data_ack !== 1'b0) begin
        $display("FAIL midreset_drop%0d: got irv=%b drv=%b acks=%b%b required 0 0 00",
                 i, inst_rvalid, data_rvalid, inst_ack, data_ack); n_err++;
      end
      n_chk++;
      next_cycle();
    end
    reset = 1'b0;
    idle();
    @(negedge clk);
    if (inst_rvalid !== 1'b0 || dut.r_starve_cnt !== 4'd0) begin
      $display("FAIL midreset_after: got irv=%b starve=%0d required 0 0", inst_rvalid, dut.r_starve_cnt); n_err++;
    end
    n_chk++;
    next_cycle();
  endtask

  initial begin
    mem[32'h1c000000] = 32'h02800421;
    mem[32'h1c000004] = 32'h55556666;
    mem[32'h00000200] = 32'h11112222;
    mem[32'h00000300] = 32'h33334444;
    sram_rdata = 32'h0;
    test_reset();
    test_single_read();
    test_write_read();
    test_starvation();
    test_interleave();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
